// File: rtl/ahb_lsu_master.sv
// AHB master bridge for the core load/store unit.
// Takes one LSU request at a time. Alignment and type are checked when the request is accepted.
// A legal request runs one non-pipelined AHB transfer (address phase, then data phase).
// The bridge then returns one response: extended load data, or a store completion.
// rsp_err flags a pre-check fault, a bus error or a timeout.
module ahb_lsu_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_typ,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  hsel,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  input  logic                  hresp,
  input  logic [DATA_WIDTH-1:0] hrdata
);

  // Counter is wide enough to hold TIMEOUT itself; TIMEOUT = 0 keeps a 1-bit idle counter.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_next;
  logic [2:0]            r_typ, w_typ_next;
  logic                  r_write, w_write_next;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_next;
  logic                  r_err, w_err_next;
  logic [CntW-1:0]       r_cnt, w_cnt_next;

  logic                  w_illegal, w_misalign, w_pre_err;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_ext;
  logic [DATA_WIDTH-1:0] w_wlanes;
  logic [CntW-1:0]       w_cnt_inc;

  // Request pre-check: illegal funct3 or misaligned address.
  always_comb begin
    w_illegal  = 1'b0;
    w_misalign = 1'b0;
    case (req_typ)
      3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
      3'b100, 3'b101:         w_illegal = req_write;  // unsigned stores do not exist
      default:                w_illegal = 1'b0;
    endcase
    case (req_typ)
      3'b001, 3'b101: w_misalign = req_addr[0];
      3'b010:         w_misalign = |req_addr[1:0];
      default:        w_misalign = 1'b0;
    endcase
    w_pre_err = w_illegal | w_misalign;
  end

  // Load lane selection and sign/zero extension from the captured address and type.
  always_comb begin
    w_byte = hrdata[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? hrdata[31:16] : hrdata[15:0];
    case (r_typ)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {24'h000000, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_ext = {16'h0000, w_half};
      default: w_load_ext = hrdata;
    endcase
  end

  // Store data replicated across byte lanes so the slave can pick any lane.
  always_comb begin
    case (r_typ[1:0])
      2'b00:   w_wlanes = {4{r_wdata[7:0]}};
      2'b01:   w_wlanes = {2{r_wdata[15:0]}};
      default: w_wlanes = r_wdata;
    endcase
  end

  // Next-state, capture and response logic.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_wdata_next = r_wdata;
    w_typ_next   = r_typ;
    w_write_next = r_write;
    w_rdata_next = r_rdata;
    w_err_next   = r_err;
    w_cnt_next   = r_cnt;
    w_cnt_inc    = r_cnt + CntW'(1);
    case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_addr_next  = req_addr;
          w_wdata_next = req_wdata;
          w_typ_next   = req_typ;
          w_write_next = req_write;
          w_rdata_next = '0;
          w_err_next   = w_pre_err;
          w_cnt_next   = '0;
          w_state_next = w_pre_err ? StResp : StAddr;
        end
      end
      StAddr: begin
        w_cnt_next   = '0;
        w_state_next = StData;
      end
      StData: begin
        if (hready) begin
          w_err_next   = hresp;
          w_rdata_next = (hresp || r_write) ? '0 : w_load_ext;
          w_state_next = StResp;
        end else begin
          if (r_cnt != CntMax) begin
            w_cnt_next = w_cnt_inc;
          end
          if ((TIMEOUT != 0) && (w_cnt_inc == CntMax)) begin
            w_err_next   = 1'b1;
            w_rdata_next = '0;
            w_state_next = StResp;
          end
        end
      end
      StResp: begin
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_wdata <= '0;
      r_typ   <= '0;
      r_write <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_wdata <= w_wdata_next;
      r_typ   <= w_typ_next;
      r_write <= w_write_next;
      r_rdata <= w_rdata_next;
      r_err   <= w_err_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Outputs decoded from state and captured registers only.
  assign req_ready = (r_state == StIdle);
  assign hsel      = (r_state == StAddr) || (r_state == StData);
  assign haddr     = hsel ? r_addr : '0;
  assign hwrite    = hsel & r_write;
  assign hsize     = hsel ? r_typ : 3'b000;
  assign hwdata    = ((r_state == StData) && r_write) ? w_wlanes : '0;
  assign rsp_valid = (r_state == StResp);
  assign rsp_rdata = rsp_valid ? r_rdata : '0;
  assign rsp_err   = rsp_valid & r_err;

endmodule

// File: tb/tb_ahb_lsu_master.sv
// Self-checking bench for ahb_lsu_master. It uses a reactive AHB slave with a byte memory.
// A separate byte-level reference model predicts every response.
module tb_ahb_lsu_master;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_typ = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;
  logic [31:0] hrdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave memory and an independent reference copy.
  logic [7:0] s_mem [1024];
  logic [7:0] m_mem [1024];
  int         cfg_wait = 0;
  logic       cfg_resp = 1'b0;

  bit          s_data = 1'b0;
  int          s_wait = 0;
  int          s_hsel_cnt = 0;
  logic [31:0] s_haddr = '0;
  logic        s_hwrite = 1'b0;
  logic [2:0]  s_hsize = '0;
  logic [31:0] s_hwdata = '0;

  always #5 clk = ~clk;

  ahb_lsu_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_typ  (req_typ),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .hsel     (hsel),
    .haddr    (haddr),
    .hwrite   (hwrite),
    .hsize    (hsize),
    .hwdata   (hwdata),
    .hready   (hready),
    .hresp    (hresp),
    .hrdata   (hrdata)
  );

  // Reactive slave: inputs are updated mid-cycle and apply to the following edge.
  always @(negedge clk) begin
    if (!hsel) begin
      s_data = 1'b0;
      hready = 1'($urandom);
      hresp  = 1'($urandom);
      hrdata = $urandom;
    end else if (!s_data) begin
      s_hsel_cnt++;
      s_haddr  = haddr;
      s_hwrite = hwrite;
      s_hsize  = hsize;
      s_data   = 1'b1;
      s_wait   = cfg_wait;
      hready   = 1'($urandom);
      hresp    = 1'($urandom);
    end else begin
      s_hsel_cnt++;
      if (s_wait > 0) begin
        s_wait--;
        hready = 1'b0;
        hresp  = 1'($urandom);
        hrdata = $urandom;
      end else begin
        int base;
        int idx;
        int nb;
        int lane;
        base     = int'(s_haddr[9:2]) * 4;
        idx      = int'(s_haddr[9:0]);
        lane     = int'(s_haddr[1:0]);
        nb       = (s_hsize[1:0] == 2'b00) ? 1 : (s_hsize[1:0] == 2'b01) ? 2 : 4;
        hready   = 1'b1;
        hresp    = cfg_resp;
        hrdata   = {s_mem[base+3], s_mem[base+2], s_mem[base+1], s_mem[base]};
        s_hwdata = hwdata;
        if (s_hwrite && !cfg_resp) begin
          for (int i = 0; i < nb; i++) s_mem[idx+i] = s_hwdata[8*(lane+i) +: 8];
        end
        s_data = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang want finish");
    $fatal(1, "watchdog");
  end

  // Reference model: byte-addressed arithmetic, no lane logic.
  function automatic bit model_pre_err(input logic w, input logic [31:0] a, input logic [2:0] t);
    bit ill;
    bit mis;
    ill = (t == 3) || (t == 6) || (t == 7) || (w && (t == 4 || t == 5));
    mis = ((t == 1 || t == 5) && (a % 2 != 0)) || (t == 2 && (a % 4 != 0));
    return ill || mis;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] t);
    int unsigned b;
    int unsigned h;
    b = m_mem[a];
    h = m_mem[a] + 256 * m_mem[a+1];
    case (t)
      3'd0:    return (b > 127) ? (32'(b) | 32'hFFFFFF00) : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h > 32767) ? (32'(h) | 32'hFFFF0000) : 32'(h);
      3'd5:    return 32'(h);
      default: return 32'(m_mem[a]) + 32'(m_mem[a+1]) * 256 + 32'(m_mem[a+2]) * 65536 +
                      32'(m_mem[a+3]) * 16777216;
    endcase
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                      input logic [2:0] t);
    int nb;
    nb = (t == 0) ? 1 : (t == 1) ? 2 : 4;
    for (int i = 0; i < nb; i++) m_mem[a+i] = 8'((d >> (8 * i)) & 32'hFF);
  endfunction

  // Drives one request and measures the response; the callers do the comparisons.
  task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] t, output int lat, output logic [31:0] rd,
                          output logic er, output int hc, output logic rdy);
    int c0;
    bit got;
    @(negedge clk);
    #1;
    c0        = s_hsel_cnt;
    rdy       = req_ready;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_typ   = t;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_typ   = 3'($urandom);
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        rd  = rsp_rdata;
        er  = rsp_err;
        got = 1'b1;
      end
    end
    #1;
    hc = s_hsel_cnt - c0;
  endtask

  task automatic test_reset;
    #3;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_err, hsel, hwrite} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 10000", {req_ready, rsp_valid, rsp_err, hsel, hwrite});
    end
    n_tests++;
    if ({rsp_rdata, haddr, hsize, hwdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h want zeros", rsp_rdata, haddr, hsize, hwdata);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loads;
    int lat;
    int hc;
    logic [31:0] rd;
    logic er;
    logic rdy;
    logic [31:0] addrs [4];
    logic [2:0]  typs [4];
    logic [31:0] exp [4];
    cfg_wait = 0;
    cfg_resp = 1'b0;
    addrs = '{32'h100, 32'h103, 32'h103, 32'h102};
    typs  = '{3'b010, 3'b000, 3'b100, 3'b001};
    exp   = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD};
    for (int i = 0; i < 4; i++) begin
      run_xfer(1'b0, addrs[i], 32'h0, typs[i], lat, rd, er, hc, rdy);
      n_tests++;
      if (rd !== exp[i] || er !== 1'b0) begin
        n_fail++;
        $display("FAIL load_%0d: got %h err %b want %h err 0", i, rd, er, exp[i]);
      end
      n_tests++;
      if (lat != 3 || hc != 2 || rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL load_lat_%0d: got lat %0d hsel %0d rdy %b want 3 2 1", i, lat, hc, rdy);
      end
    end
  endtask

  task automatic test_store_wait;
    int lat;
    int hc;
    logic [31:0] rd;
    logic er;
    logic rdy;
    cfg_wait = 2;
    run_xfer(1'b1, 32'h202, 32'h00001234, 3'b001, lat, rd, er, hc, rdy);
    model_store(32'h202, 32'h00001234, 3'b001);
    n_tests++;
    if (s_hwdata !== 32'h12341234) begin
      n_fail++;
      $display("FAIL sh_hwdata: got %h want 12341234", s_hwdata);
    end
    n_tests++;
    if (lat != 5 || hc != 4 || er !== 1'b0 || rd !== '0) begin
      n_fail++;
      $display("FAIL sh_rsp: got lat %0d hsel %0d err %b rd %h want 5 4 0 0", lat, hc, er, rd);
    end
    cfg_wait = 0;
    run_xfer(1'b0, 32'h200, 32'h0, 3'b010, lat, rd, er, hc, rdy);
    n_tests++;
    if (rd !== model_load(32'h200, 3'b010)) begin
      n_fail++;
      $display("FAIL sh_readback: got %h want %h", rd, model_load(32'h200, 3'b010));
    end
  endtask

  task automatic test_precheck;
    int lat;
    int hc;
    logic [31:0] rd;
    logic er;
    logic rdy;
    logic        ws [3];
    logic [31:0] as [3];
    logic [2:0]  ts [3];
    ws = '{1'b0, 1'b1, 1'b1};
    as = '{32'h101, 32'h100, 32'h104};
    ts = '{3'b010, 3'b011, 3'b100};
    for (int i = 0; i < 3; i++) begin
      run_xfer(ws[i], as[i], 32'hA5A5A5A5, ts[i], lat, rd, er, hc, rdy);
      n_tests++;
      if (lat != 1 || er !== 1'b1 || rd !== '0 || hc != 0) begin
        n_fail++;
        $display("FAIL precheck_%0d: got lat %0d err %b rd %h hsel %0d want 1 1 0 0",
                 i, lat, er, rd, hc);
      end
    end
  endtask

  task automatic test_timeout_hresp;
    int lat;
    int hc;
    logic [31:0] rd;
    logic er;
    logic rdy;
    cfg_wait = 20;
    run_xfer(1'b0, 32'h100, 32'h0, 3'b010, lat, rd, er, hc, rdy);
    n_tests++;
    if (lat != TO + 2 || er !== 1'b1 || rd !== '0 || hc != TO + 1) begin
      n_fail++;
      $display("FAIL timeout: got lat %0d err %b rd %h hsel %0d want %0d 1 0 %0d",
               lat, er, rd, hc, TO + 2, TO + 1);
    end
    cfg_wait = TO - 1;
    run_xfer(1'b0, 32'h100, 32'h0, 3'b010, lat, rd, er, hc, rdy);
    n_tests++;
    if (lat != TO + 2 || er !== 1'b0 || rd !== model_load(32'h100, 3'b010)) begin
      n_fail++;
      $display("FAIL timeout_edge: got lat %0d err %b rd %h want %0d 0 %h",
               lat, er, rd, TO + 2, model_load(32'h100, 3'b010));
    end
    cfg_wait = 0;
    cfg_resp = 1'b1;
    run_xfer(1'b0, 32'h100, 32'h0, 3'b010, lat, rd, er, hc, rdy);
    cfg_resp = 1'b0;
    n_tests++;
    if (lat != 3 || er !== 1'b1 || rd !== '0) begin
      n_fail++;
      $display("FAIL hresp: got lat %0d err %b rd %h want 3 1 0", lat, er, rd);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int hc;
    logic [31:0] rd;
    logic er;
    logic rdy;
    bit seen;
    cfg_wait = 6;
    @(negedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h100;
    req_typ   = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (hsel !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got hsel %b ready %b want 0 1", hsel, req_ready);
    end
    @(negedge clk);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_rsp: got rsp_valid %b want 0", seen);
    end
    cfg_wait = 0;
    run_xfer(1'b0, 32'h100, 32'h0, 3'b010, lat, rd, er, hc, rdy);
    n_tests++;
    if (lat != 3 || er !== 1'b0 || rd !== model_load(32'h100, 3'b010)) begin
      n_fail++;
      $display("FAIL reset_mid_next: got lat %0d err %b rd %h want 3 0 %h",
               lat, er, rd, model_load(32'h100, 3'b010));
    end
  endtask

  task automatic test_random;
    int lat;
    int hc;
    logic [31:0] rd;
    logic er;
    logic rdy;
    logic w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0] t;
    int e_lat;
    int e_hc;
    logic e_err;
    logic [31:0] e_rd;
    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom);
      t = 3'($urandom);
      a = 32'($urandom_range(0, 1020));
      if ($urandom_range(0, 3) != 0) begin
        if (t == 2) a = a & 32'hFFFFFFFC;
        else if (t == 1 || t == 5) a = a & 32'hFFFFFFFE;
      end
      d        = $urandom;
      cfg_wait = ($urandom_range(0, 5) == 0) ? int'($urandom_range(8, 11))
                                             : int'($urandom_range(0, 3));
      cfg_resp = ($urandom_range(0, 7) == 0);
      if (model_pre_err(w, a, t)) begin
        e_lat = 1;
        e_hc  = 0;
        e_err = 1'b1;
        e_rd  = '0;
      end else if (cfg_wait >= int'(TO)) begin
        e_lat = TO + 2;
        e_hc  = TO + 1;
        e_err = 1'b1;
        e_rd  = '0;
      end else begin
        e_lat = 3 + cfg_wait;
        e_hc  = 2 + cfg_wait;
        e_err = cfg_resp;
        e_rd  = (cfg_resp || w) ? 32'h0 : model_load(a, t);
      end
      run_xfer(w, a, d, t, lat, rd, er, hc, rdy);
      if (!model_pre_err(w, a, t) && cfg_wait < int'(TO) && !cfg_resp && w) model_store(a, d, t);
      n_tests++;
      if (rd !== e_rd || er !== e_err) begin
        n_fail++;
        $display("FAIL rand_%0d_data: w%b t%0d a %h got %h err %b want %h err %b",
                 n, w, t, a, rd, er, e_rd, e_err);
      end
      n_tests++;
      if (lat != e_lat || hc != e_hc) begin
        n_fail++;
        $display("FAIL rand_%0d_timing: got lat %0d hsel %0d want %0d %0d",
                 n, lat, hc, e_lat, e_hc);
      end
      if (e_hc != 0) begin
        n_tests++;
        if (s_haddr !== a || s_hwrite !== w || s_hsize !== t) begin
          n_fail++;
          $display("FAIL rand_%0d_ctrl: got %h %b %0d want %h %b %0d",
                   n, s_haddr, s_hwrite, s_hsize, a, w, t);
        end
      end
    end
    cfg_resp = 1'b0;
    cfg_wait = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      s_mem[i] = 8'($urandom);
      m_mem[i] = s_mem[i];
    end
    s_mem[256] = 8'hEF; s_mem[257] = 8'hBE; s_mem[258] = 8'hAD; s_mem[259] = 8'hDE;
    m_mem[256] = 8'hEF; m_mem[257] = 8'hBE; m_mem[258] = 8'hAD; m_mem[259] = 8'hDE;
    test_reset();
    test_loads();
    test_store_wait();
    test_precheck();
    test_timeout_hresp();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lsu_master.md
Name: ahb_lsu_master

Overview:
- AHB master bridge between the core load/store unit and the AHB RAM slave (ram_top).
- Accepts one LSU request at a time and checks alignment and type.
- Drives a single non-pipelined AHB transfer (address phase, then data phase), returns sign/zero-extended load data or a store completion, and flags bus errors and timeouts.

Parameters:
- ADDR_WIDTH, 32, LSU/AHB address width.
- DATA_WIDTH, 32, LSU/AHB data width (fixed at 32; byte-lane logic assumes 4 lanes).
- TIMEOUT, 256, maximum data-phase cycles with hready low before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  LSU request valid
- req_ready  out  1  bridge can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- req_typ  in  3  RISC-V funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal type, hresp error or timeout
- hsel  out  1  slave select, high during address and data phase
- haddr  out  ADDR_WIDTH  transfer address
- hwrite  out  1  transfer direction
- hsize  out  3  copy of req_typ, used by the slave as rwtyp
- hwdata  out  DATA_WIDTH  lane-replicated store data, valid in data phase
- hready  in  1  slave ready
- hresp  in  1  slave error (1 = ERROR)
- hrdata  in  DATA_WIDTH  slave read data

Behaviour:
- Reset (rst high, async): state IDLE; every output 0 except req_ready = 1; timeout counter 0.
- A request is accepted on a cycle with req_valid && req_ready. All request fields are captured into registers. req_ready is high only in IDLE.
- Pre-check at accept time:
  - Illegal typ: 011, 110, 111, or loads/stores using 100/101 with req_write = 1.
  - Misaligned: h/hu with addr[0] set; w with addr[1:0] != 0.
  - Either condition goes to RESP with rsp_err = 1; no AHB activity.
- FSM:
  - IDLE -> ADDR on an accepted, legal request.
  - ADDR: one cycle. hsel = 1; haddr, hwrite, hsize driven from the captured registers. Always moves to DATA.
  - DATA: hsel stays 1 and address/control are held. hwdata is driven for stores: b replicated to 4 lanes, h replicated to 2 lanes, w unchanged.
    - Completes on hready = 1. On completion, hrdata is sampled (loads) and hresp is sampled.
    - While hready = 0, the timeout counter increments. When it reaches TIMEOUT, the transfer aborts with rsp_err = 1.
  - RESP: one cycle. rsp_valid = 1; hsel = 0. Next state is IDLE.
- Latency for a legal access: accept cycle, then ADDR (+1), DATA (+1 plus any wait cycles), then RESP. rsp_valid is asserted 3 cycles after accept when the slave has zero wait states. A pre-check error responds 1 cycle after accept.
- Load extraction uses captured addr[1:0]:
  - b: byte lane addr[1:0], sign-extended.
  - bu: same byte lane, zero-extended.
  - h: halfword lane addr[1], sign-extended.
  - hu: same halfword lane, zero-extended.
  - w: full word.
- Error priority: pre-check > timeout > hresp. On any error, rsp_rdata = 0.
- hresp = 1 with hready = 0 is treated as wait; only the hresp value sampled when hready = 1 counts.
- The timeout counter clears on entering ADDR and saturates at TIMEOUT.
- req_valid in any non-IDLE state is ignored (req_ready = 0). There is no back-pressure on rsp_valid; the LSU must consume the response in the cycle it appears.
- rst asserted mid-transfer returns the block to IDLE immediately, drops hsel and produces no response; the in-flight access is lost.
- All outputs are registered or decoded from the state and captured registers only; there is no combinational path from req_* to h* outputs.

Test Plan:
- Load word, zero-wait slave, RAM[0x100] = 0xDEADBEEF -> rsp_valid 3 cycles after accept, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- lb at 0x103 and lbu at 0x103, same data -> rsp_rdata = 0xFFFFFFDE and 0x000000DE respectively; lh at 0x102 -> 0xFFFFDEAD.
- sh at 0x202, wdata = 0x00001234, slave inserts 2 wait cycles -> hwdata = 0x12341234, hsel high 4 cycles, rsp_valid 5 cycles after accept, rsp_err = 0.
- lw at 0x101 and sw with typ 011 -> rsp_err = 1 one cycle after accept, hsel never asserted.
- Slave holds hready = 0 with TIMEOUT = 8 -> rsp_err = 1 after 8 wait cycles; a second slave returning hresp = 1 with hready = 1 -> rsp_err = 1, rsp_rdata = 0.
- rst pulsed during DATA -> hsel = 0 and req_ready = 1 asynchronously, no rsp_valid; the next lw completes normally.
